// File: rtl/clz_pipe_unit.sv
// -----------------------------------------------------------------------------
// clz_pipe_unit
//
// Purpose:
//   Pipelined bit-count unit. For each operation it computes one of four
//   counts on a WIDTH-bit operand and a normalised copy of the operand:
//     in_mode 00 CLZ : leading zeros from the MSB (operand 0 -> WIDTH)
//     in_mode 01 CLO : leading ones from the MSB (all ones -> WIDTH)
//     in_mode 10 CTZ : trailing zeros from the LSB (operand 0 -> WIDTH)
//     in_mode 11 CLS : bits below the MSB equal to the MSB (0..WIDTH-1)
//   Normalised operand: operand << count for CLZ/CLO/CLS, operand >> count
//   (logical) for CTZ, and 0 whenever count == WIDTH.
//   Results move through PIPE_STAGES register stages with an opaque tag.
//
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   synchronous active-low reset, flushes all in-flight work
//   in_valid   in   operation present on in_*
//   in_ready   out  unit accepts an operation this cycle
//   in_data    in   operand [WIDTH]
//   in_mode    in   operation select [2]
//   in_tag     in   pass-through tag [TAG_W]
//   out_valid  out  result present on out_*
//   out_ready  in   consumer accepts the result this cycle
//   out_count  out  count [$clog2(WIDTH)+1]
//   out_all    out  out_count == WIDTH
//   out_norm   out  normalised operand [WIDTH]
//   out_tag    out  tag of this result [TAG_W]
//
// Handshake: a transfer happens on a rising edge where valid && ready are
// both high. in_ready never looks at in_valid; out_* hold steady while
// out_valid && !out_ready. Every stage is a full slot, so a full pipeline
// accepts and delivers in the same cycle and sustains one op per cycle.
// -----------------------------------------------------------------------------
module clz_pipe_unit #(
    parameter int WIDTH       = 32,
    parameter int PIPE_STAGES = 2,
    parameter int TAG_W       = 4,
    localparam int CNT_W      = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [1:0]       in_mode,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] out_count,
    output logic             out_all,
    output logic [WIDTH-1:0] out_norm,
    output logic [TAG_W-1:0] out_tag
);

    // ---------------------------------------------------------------------
    // Count and normalise. All four counts reduce to a leading-zero count
    // of a mode-dependent source vector:
    //   CLO -> CLZ of ~D, CTZ -> CLZ of bit-reversed D,
    //   CLS -> CLZ of (D xor sign) minus one (its MSB is always 0, so the
    //          leading-zero count is at least 1 and the result stays < WIDTH).
    // ---------------------------------------------------------------------
    logic [WIDTH-1:0] w_rev;
    logic [WIDTH-1:0] w_sign_x;
    logic [WIDTH-1:0] w_src;
    logic [CNT_W-1:0] w_lz;
    logic [CNT_W-1:0] w_cnt;
    logic [WIDTH-1:0] w_norm;

    always_comb begin
        w_rev    = '0;
        w_sign_x = in_data ^ {WIDTH{in_data[WIDTH-1]}};
        for (int i = 0; i < WIDTH; i++) begin
            w_rev[i] = in_data[WIDTH-1-i];
        end

        case (in_mode)
            2'b00:   w_src = in_data;
            2'b01:   w_src = ~in_data;
            2'b10:   w_src = w_rev;
            default: w_src = w_sign_x;
        endcase

        // Ascending scan: the last hit is the highest set bit.
        w_lz = CNT_W'(WIDTH);
        for (int i = 0; i < WIDTH; i++) begin
            if (w_src[i]) begin
                w_lz = CNT_W'(WIDTH - 1 - i);
            end
        end

        w_cnt = (in_mode == 2'b11) ? (w_lz - CNT_W'(1)) : w_lz;

        if (w_cnt == CNT_W'(WIDTH)) begin
            w_norm = '0;
        end else if (in_mode == 2'b10) begin
            w_norm = in_data >> w_cnt;
        end else begin
            w_norm = in_data << w_cnt;
        end
    end

    // ---------------------------------------------------------------------
    // Pipeline. The mode only steers the count/normalise step, which is
    // resolved at acceptance, so each stage carries the finished result.
    // ---------------------------------------------------------------------
    logic             r_valid [PIPE_STAGES];
    logic [CNT_W-1:0] r_count [PIPE_STAGES];
    logic [WIDTH-1:0] r_norm  [PIPE_STAGES];
    logic [TAG_W-1:0] r_tag   [PIPE_STAGES];

    // Stage k advances when any stage from k to the end is empty (that bubble
    // lets everything behind it move up) or the consumer takes the result.
    logic [PIPE_STAGES-1:0] w_adv;

    always_comb begin
        w_adv = '0;
        for (int k = 0; k < PIPE_STAGES; k++) begin
            w_adv[k] = out_ready;
            for (int j = k; j < PIPE_STAGES; j++) begin
                if (!r_valid[j]) begin
                    w_adv[k] = 1'b1;
                end
            end
        end
    end

    assign in_ready = rst_n & w_adv[0];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < PIPE_STAGES; k++) begin
                r_valid[k] <= 1'b0;
                r_count[k] <= '0;
                r_norm[k]  <= '0;
                r_tag[k]   <= '0;
            end
        end else begin
            if (w_adv[0]) begin
                r_valid[0] <= in_valid;
                if (in_valid) begin
                    r_count[0] <= w_cnt;
                    r_norm[0]  <= w_norm;
                    r_tag[0]   <= in_tag;
                end
            end
            for (int k = 1; k < PIPE_STAGES; k++) begin
                if (w_adv[k]) begin
                    r_valid[k] <= r_valid[k-1];
                    // Payload only moves with a real operation, so an empty
                    // slot never disturbs the registers behind out_*.
                    if (r_valid[k-1]) begin
                        r_count[k] <= r_count[k-1];
                        r_norm[k]  <= r_norm[k-1];
                        r_tag[k]   <= r_tag[k-1];
                    end
                end
            end
        end
    end

    assign out_valid = r_valid[PIPE_STAGES-1];
    assign out_count = r_count[PIPE_STAGES-1];
    assign out_norm  = r_norm[PIPE_STAGES-1];
    assign out_tag   = r_tag[PIPE_STAGES-1];
    assign out_all   = (r_count[PIPE_STAGES-1] == CNT_W'(WIDTH));

endmodule
